// File: rtl/alu_ab_datapath.sv
// SAP-style accumulator datapath: A/B registers with a registered ALU. ALU result is visible one edge after eu
// and is written back on a later edge. No backpressure: strobes act every cycle.
module alu_ab_datapath #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] ram_in,
    input  logic [W-1:0] tmp_in,
    input  logic [3:0]   opcode,
    input  logic         carry_in,
    input  logic         la_ram,
    input  logic         la_b,
    input  logic         la_alu,
    input  logic         lb_tmp,
    input  logic         lb_alu,
    input  logic         eu,
    input  logic         ea_tmp,
    input  logic         ea_ram,
    input  logic         ea_out,
    input  logic         ea_carry,
    input  logic         ercl,
    output logic [W-1:0] a_tmp_out,
    output logic [W-1:0] a_ram_out,
    output logic [W-1:0] a_out,
    output logic         a_carry,
    output logic         b_carry,
    output logic [W-1:0] alu_q,
    output logic         zero,
    output logic         carry
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_RCL = 4'b0100;

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_alu_q;
    logic         r_zero;
    logic         r_carry;

    logic [W-1:0] w_alu_res;
    logic         w_alu_carry;
    logic [W:0]   w_sum;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_alu_res   = r_a;
        w_alu_carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_alu_res   = w_sum[W-1:0];
                w_alu_carry = w_sum[W];
            end
            OP_SUB: begin
                w_alu_res   = r_a - r_b;
                w_alu_carry = (r_a < r_b);
            end
            OP_SHR: begin
                w_alu_res   = {1'b0, r_a[W-1:1]};
                w_alu_carry = r_a[0];
            end
            OP_RCL: begin
                w_alu_res   = {r_b[W-2:0], carry_in};
                w_alu_carry = r_b[W-1];
            end
            default: begin
                w_alu_res   = r_a;
                w_alu_carry = 1'b0;
            end
        endcase
    end

    // Every load reads pre-edge register values, so la_b + lb_tmp swaps A/B cleanly
    // and la_alu alongside eu takes the previous result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_alu_q <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            if (la_ram)
                r_a <= ram_in;
            else if (la_b)
                r_a <= r_b;
            else if (la_alu)
                r_a <= r_alu_q;

            if (lb_alu)
                r_b <= r_alu_q;
            else if (lb_tmp)
                r_b <= tmp_in;

            if (eu) begin
                r_alu_q <= w_alu_res;
                r_zero  <= (w_alu_res == '0);
                r_carry <= w_alu_carry;
            end
        end
    end

    assign a_tmp_out = ea_tmp   ? r_a      : '0;
    assign a_ram_out = ea_ram   ? r_a      : '0;
    assign a_out     = ea_out   ? r_a      : '0;
    assign a_carry   = ea_carry ? r_a[0]   : 1'b0;
    assign b_carry   = ercl     ? r_b[W-1] : 1'b0;
    assign alu_q     = r_alu_q;
    assign zero      = r_zero;
    assign carry     = r_carry;

endmodule

// File: tb/tb_alu_ab_datapath.sv
// Directed bench for alu_ab_datapath: stimulus queues hand-computed expectations, a monitor checks them.
module tb_alu_ab_datapath;

    logic       clk;
    logic       reset;
    logic [3:0] ram_in, tmp_in, opcode;
    logic       carry_in, la_ram, la_b, la_alu, lb_tmp, lb_alu, eu;
    logic       ea_tmp, ea_ram, ea_out, ea_carry, ercl;
    logic [3:0] a_tmp_out, a_ram_out, a_out, alu_q;
    logic       a_carry, b_carry, zero, carry;

    logic       chk_vld;
    int         n_checks;
    int         n_errors;

    typedef struct {
        string      name;
        logic [19:0] exp;
    } exp_t;

    exp_t sb_q[$];

    alu_ab_datapath #(.W(4)) dut (
        .clk(clk), .reset(reset), .ram_in(ram_in), .tmp_in(tmp_in), .opcode(opcode),
        .carry_in(carry_in), .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu),
        .lb_tmp(lb_tmp), .lb_alu(lb_alu), .eu(eu), .ea_tmp(ea_tmp), .ea_ram(ea_ram),
        .ea_out(ea_out), .ea_carry(ea_carry), .ercl(ercl), .a_tmp_out(a_tmp_out),
        .a_ram_out(a_ram_out), .a_out(a_out), .a_carry(a_carry), .b_carry(b_carry),
        .alu_q(alu_q), .zero(zero), .carry(carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares the observed output bundle against the oldest expectation.
    initial begin
        exp_t        e;
        logic [19:0] act;
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                act = {a_tmp_out, a_ram_out, a_out, a_carry, b_carry, alu_q, zero, carry};
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_empty: output presented with no expectation, got %h", act);
                end else begin
                    e = sb_q.pop_front();
                    if (act !== e.exp) begin
                        n_errors++;
                        $display("FAIL %s: got tmp=%h ram=%h out=%h ac=%b bc=%b q=%h z=%b c=%b, expected %h",
                                 e.name, act[19:16], act[15:12], act[11:8], act[7], act[6],
                                 act[5:2], act[1], act[0], e.exp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        la_ram = 0; la_b = 0; la_alu = 0; lb_tmp = 0; lb_alu = 0; eu = 0;
        ea_tmp = 0; ea_ram = 0; ea_out = 0; ea_carry = 0; ercl = 0;
    endtask

    // en = {ea_tmp, ea_ram, ea_out, ea_carry, ercl}; a/b are the hand-predicted register contents.
    task automatic check(input string name, input logic [4:0] en, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] q, input logic z, input logic c);
        exp_t e;
        clear_ctl();
        {ea_tmp, ea_ram, ea_out, ea_carry, ercl} = en;
        e.name = name;
        e.exp  = {en[4] ? a : 4'h0, en[3] ? a : 4'h0, en[2] ? a : 4'h0,
                  en[1] & a[0], en[0] & b[3], q, z, c};
        sb_q.push_back(e);
        chk_vld = 1'b1;
        tick();
        chk_vld = 1'b0;
        clear_ctl();
    endtask

    task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
        la_ram = 1; ram_in = a; lb_tmp = 1; tmp_in = b;
        tick();
        clear_ctl();
    endtask

    task automatic op(input logic [3:0] code);
        opcode = code; eu = 1;
        tick();
        clear_ctl();
    endtask

    task automatic wr_a();
        la_alu = 1;
        tick();
        clear_ctl();
    endtask

    task automatic wr_b();
        lb_alu = 1;
        tick();
        clear_ctl();
    endtask

    localparam logic [4:0] ALL = 5'b11111;

    initial begin
        n_checks = 0; n_errors = 0; chk_vld = 0;
        reset = 1; ram_in = 0; tmp_in = 0; opcode = 0; carry_in = 0;
        clear_ctl();
        tick(); tick();
        reset = 0;

        check("reset", ALL, 4'd0, 4'd0, 4'd0, 0, 0);

        load_ab(4'd9, 4'd5);
        check("load", ALL, 4'd9, 4'd5, 4'd0, 0, 0);
        check("gate_off", 5'b00000, 4'd9, 4'd5, 4'd0, 0, 0);
        check("ea_out_only", 5'b00100, 4'd9, 4'd5, 4'd0, 0, 0);

        op(4'b0001);
        check("add_eu", ALL, 4'd9, 4'd5, 4'd14, 0, 0);
        wr_a();
        check("add_wb", ALL, 4'd14, 4'd5, 4'd14, 0, 0);

        // la_alu with eu: A takes the old result 14, ALU computes 2+5.
        la_ram = 1; ram_in = 4'd2; tick(); clear_ctl();
        opcode = 4'b0001; eu = 1; la_alu = 1; tick(); clear_ctl();
        check("no_bypass", ALL, 4'd14, 4'd5, 4'd7, 0, 0);

        load_ab(4'd9, 4'd9); op(4'b0001); wr_a();
        check("add_carry", ALL, 4'd2, 4'd9, 4'd2, 0, 1);

        load_ab(4'd3, 4'd3); op(4'b0010);
        check("sub_zero", ALL, 4'd3, 4'd3, 4'd0, 1, 0);

        load_ab(4'd3, 4'd5); op(4'b0010);
        check("sub_borrow", ALL, 4'd3, 4'd5, 4'd14, 0, 1);

        load_ab(4'd9, 4'd9); op(4'b0101); wr_a();
        check("shr", ALL, 4'd4, 4'd9, 4'd4, 0, 1);

        carry_in = 0; op(4'b0100); wr_b();
        check("rcl", ALL, 4'd4, 4'd2, 4'd2, 0, 1);

        carry_in = 1; op(4'b0100); carry_in = 0;
        check("rcl_cin", ALL, 4'd4, 4'd2, 4'd5, 0, 0);

        op(4'b1111);
        check("op_other", ALL, 4'd4, 4'd2, 4'd4, 0, 0);

        load_ab(4'd9, 4'd3);
        tmp_in = 4'd9; la_b = 1; lb_tmp = 1; tick(); clear_ctl();
        check("xchg", ALL, 4'd3, 4'd9, 4'd4, 0, 0);

        ram_in = 4'd6; la_ram = 1; la_b = 1; la_alu = 1;
        tmp_in = 4'd15; lb_tmp = 1; lb_alu = 1;
        tick(); clear_ctl();
        check("prio", ALL, 4'd6, 4'd4, 4'd4, 0, 0);

        op(4'b1111);
        la_b = 1; la_alu = 1; tick(); clear_ctl();
        check("prio_la_b", ALL, 4'd4, 4'd4, 4'd6, 0, 0);

        reset = 1; la_ram = 1; ram_in = 4'd9; lb_tmp = 1; tmp_in = 4'd8;
        eu = 1; opcode = 4'b0001;
        tick(); clear_ctl(); reset = 0;
        check("reset_mid", ALL, 4'd0, 4'd0, 4'd0, 0, 0);

        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
